// File: rtl/text_shifter.sv
// Text-mode pixel serializer: fetches 32 character codes per scanline from VRAM,
// looks up font rows and shifts out 256 pixels with optional per-character inverse.
module text_shifter (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       line_start,
  input  logic [3:0] text_row,
  input  logic [3:0] scan,
  output logic [8:0] vram_addr,
  input  logic [7:0] vram_data,
  output logic [9:0] font_addr,
  input  logic [7:0] font_data,
  output logic       pixel,
  output logic       active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE0 = 2'd1,
    PRE1 = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [4:0] col_reg;
  logic [4:0] disp_col_reg;
  logic [2:0] phase_reg;
  logic [7:0] code_reg;
  logic [7:0] shifter_reg;
  logic [8:0] vram_addr_reg;
  logic       pixel_reg;
  logic       active_reg;

  logic [7:0] load_val;
  logic       line_done;

  logic start_line;
  logic latch_code;
  logic load_first;
  logic load_next;
  logic shift_en;
  logic advance;
  logic finish;

  // Bit 6 of the character code carries no meaning for this display.
  logic code_bit6_unused;
  assign code_bit6_unused = code_reg[6];

  // Last pixel of column 31 is on screen now.
  assign line_done = active_reg && (phase_reg == 3'd7) && (disp_col_reg == 5'd31);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_inverse
      assign load_val[gi] = font_data[gi] ^ code_reg[7];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else if (pix_en) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (line_start) state_next = PRE0;
      PRE0: state_next = PRE1;
      PRE1: state_next = RUN;
      RUN:  if (line_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-slot datapath strobes; all are qualified by pix_en so that
  // a stalled slot leaves every register untouched.
  always_comb begin
    start_line = 1'b0;
    latch_code = 1'b0;
    load_first = 1'b0;
    load_next  = 1'b0;
    shift_en   = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    if (pix_en) begin
      case (state_reg)
        IDLE: start_line = line_start;
        PRE0: ;
        PRE1: latch_code = 1'b1;
        RUN: begin
          if (!active_reg) begin
            load_first = 1'b1;
            advance    = 1'b1;
          end else if (phase_reg == 3'd7) begin
            if (line_done) begin
              finish = 1'b1;
            end else begin
              load_next = 1'b1;
              advance   = (col_reg != 5'd31);
            end
          end else begin
            shift_en   = 1'b1;
            latch_code = (phase_reg == 3'd1) && (disp_col_reg != 5'd31);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg       <= 5'd0;
      disp_col_reg  <= 5'd0;
      phase_reg     <= 3'd0;
      code_reg      <= 8'd0;
      shifter_reg   <= 8'd0;
      vram_addr_reg <= 9'd0;
      pixel_reg     <= 1'b0;
      active_reg    <= 1'b0;
    end else begin
      if (start_line) begin
        col_reg       <= 5'd0;
        vram_addr_reg <= {text_row, 5'd0};
      end
      // The fetch column runs one ahead of the displayed column and stops at 31.
      if (advance) begin
        col_reg       <= col_reg + 5'd1;
        vram_addr_reg <= {text_row, col_reg + 5'd1};
      end
      if (latch_code) begin
        code_reg <= vram_data;
      end
      if (load_first || load_next) begin
        shifter_reg <= load_val;
        pixel_reg   <= load_val[7];
        phase_reg   <= 3'd0;
        active_reg  <= 1'b1;
      end
      if (load_first) begin
        disp_col_reg <= 5'd0;
      end
      if (load_next) begin
        disp_col_reg <= disp_col_reg + 5'd1;
      end
      if (shift_en) begin
        shifter_reg <= {shifter_reg[6:0], 1'b0};
        pixel_reg   <= shifter_reg[6];
        phase_reg   <= phase_reg + 3'd1;
      end
      if (finish) begin
        shifter_reg <= 8'd0;
        pixel_reg   <= 1'b0;
        active_reg  <= 1'b0;
        phase_reg   <= 3'd0;
      end
    end
  end

  assign vram_addr = vram_addr_reg;
  assign font_addr = {code_reg[5:0], scan};
  assign pixel     = pixel_reg;
  assign active    = active_reg;

endmodule

// File: tb/tb_text_shifter.sv
// Bench for text_shifter: VRAM/font models, a slot-count line model checked every
// cycle, and directed scenarios with hand-computed literal expectations.
module tb_text_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_en;
  logic       line_start;
  logic [3:0] text_row;
  logic [3:0] scan;
  logic [8:0] vram_addr;
  logic [7:0] vram_data;
  logic [9:0] font_addr;
  logic [7:0] font_data;
  logic       pixel;
  logic       active;

  int n_vec = 0;
  int n_err = 0;

  text_shifter dut (
    .clk        (clk),
    .reset      (reset),
    .pix_en     (pix_en),
    .line_start (line_start),
    .text_row   (text_row),
    .scan       (scan),
    .vram_addr  (vram_addr),
    .vram_data  (vram_data),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .pixel      (pixel),
    .active     (active)
  );

  always #5 clk = ~clk;

  // VRAM with one clock of registered read latency.
  logic [7:0] mem [512];
  logic [7:0] vram_q = 8'd0;
  always @(posedge clk) vram_q <= mem[vram_addr];
  assign vram_data = vram_q;

  function automatic logic [7:0] font_fn(input logic [5:0] g, input logic [3:0] s);
    int v;
    if (g == 6'd1 && s == 4'd3) return 8'h08;
    v = int'(g) * 29 + int'(s) * 7 + 53;
    return v[7:0];
  endfunction

  assign font_data = font_fn(font_addr[9:4], font_addr[3:0]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Line model: counts completed slots since the accepted line_start.
  logic       m_busy = 1'b0;
  int         m_done = 0;
  logic [3:0] m_row = 4'd0;
  logic [8:0] m_addr_idle = 9'd0;
  logic       chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy      <= 1'b0;
      m_done      <= 0;
      m_addr_idle <= 9'd0;
    end else if (pix_en) begin
      if (!m_busy) begin
        if (line_start) begin
          m_busy <= 1'b1;
          m_done <= 1;
          m_row  <= text_row;
        end
      end else begin
        m_done <= m_done + 1;
        if (m_done == 259) begin
          m_busy      <= 1'b0;
          m_addr_idle <= {m_row, 5'd31};
        end
      end
    end
  end

  function automatic logic exp_pix(input int i);
    int         c;
    logic [8:0] a;
    logic [7:0] code;
    logic [7:0] fr;
    c    = i / 8;
    a    = {m_row, c[4:0]};
    code = mem[a];
    fr   = font_fn(code[5:0], scan) ^ {8{code[7]}};
    return fr[7 - (i % 8)];
  endfunction

  always @(negedge clk) begin
    logic       e_pix;
    logic       e_act;
    logic [8:0] e_addr;
    int         c;
    if (chk_en) begin
      if (m_busy) begin
        e_act = (m_done >= 4);
        e_pix = (m_done >= 4) ? exp_pix(m_done - 4) : 1'b0;
        c = (m_done < 4) ? 0 : 1 + (m_done - 4) / 8;
        if (c > 31) c = 31;
        e_addr = {m_row, c[4:0]};
      end else begin
        e_act  = 1'b0;
        e_pix  = 1'b0;
        e_addr = m_addr_idle;
      end
      check("pixel", 32'(pixel), 32'(e_pix));
      check("active", 32'(active), 32'(e_act));
      check("vram_addr", 32'(vram_addr), 32'(e_addr));
    end
  end

  logic       cap[$];
  logic       ref_q[$];
  logic [8:0] addr_q[$];
  int         first_act;
  int         last_act;
  logic [8:0] addr_s1;

  function automatic logic [7:0] grp(input int g);
    logic [7:0] r;
    r = 8'hxx;
    if (cap.size() >= g * 8 + 8)
      for (int b = 0; b < 8; b++) r[7 - b] = cap[g * 8 + b];
    return r;
  endfunction

  // Drives one line of 263 slots; optional second line_start and mid-line reset.
  task automatic run_line(input bit toggle, input int extra_ls, input int rst_at);
    cap.delete();
    addr_q.delete();
    first_act = -1;
    last_act  = -1;
    addr_s1   = 9'h1ff;
    for (int k = 0; k <= 262; k++) begin
      pix_en     = 1'b1;
      line_start = (k == 0) || (k == extra_ls);
      reset      = (k == rst_at);
      @(negedge clk);
      if (active && first_act < 0) first_act = k;
      if (active) last_act = k;
      if (active) cap.push_back(pixel);
      if (k == 1) addr_s1 = vram_addr;
      if (k >= 1 && (addr_q.size() == 0 || addr_q[$] != vram_addr)) addr_q.push_back(vram_addr);
      @(posedge clk); #2;
      reset = 1'b0;
      if (toggle) begin
        pix_en     = 1'b0;
        line_start = 1'b1;
        @(posedge clk); #2;
      end
      if (k == rst_at) break;
    end
    pix_en     = 1'b0;
    line_start = 1'b0;
  endtask

  initial begin
    int diffs;
    reset      = 1'b1;
    pix_en     = 1'b0;
    line_start = 1'b0;
    text_row   = 4'd0;
    scan       = 4'd3;
    for (int i = 0; i < 512; i++) mem[i] = 8'h01;
    repeat (3) @(posedge clk);
    #2;
    reset  = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_font_addr", 32'(font_addr), 32'({6'd0, scan}));
    check("rst_vram_addr", 32'(vram_addr), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    @(posedge clk); #2;
    repeat (3) @(posedge clk);
    #2;

    // Uniform code 0x01 on row 2.
    text_row = 4'd2;
    run_line(1'b0, -1, -1);
    check("basic_count", cap.size(), 256);
    check("basic_addr_slot1", 32'(addr_s1), 32'h040);
    check("basic_first_active", first_act, 4);
    check("basic_last_active", last_act, 259);
    check("basic_group0", 32'(grp(0)), 32'h08);
    diffs = 0;
    for (int g = 0; g < 32; g++) if (grp(g) !== 8'h08) diffs++;
    check("basic_all_groups", diffs, 0);
    ref_q = cap;
    $display("line basic: %0d pixels, active slots %0d..%0d", cap.size(), first_act, last_act);

    // pix_en toggling, with line_start held high on the stalled cycles.
    run_line(1'b1, -1, -1);
    diffs = 0;
    if (cap.size() != ref_q.size()) diffs = 999;
    else for (int i = 0; i < cap.size(); i++) if (cap[i] !== ref_q[i]) diffs++;
    check("toggle_seq", diffs, 0);
    diffs = 0;
    if (addr_q.size() != 32) diffs = 999;
    else for (int i = 0; i < 32; i++) if (addr_q[i] !== 9'(9'h040 + i)) diffs++;
    check("toggle_addr_seq", diffs, 0);
    $display("line toggle: %0d pixels, %0d addresses", cap.size(), addr_q.size());

    // Inverse character in column 0.
    mem[9'h040] = 8'h81;
    run_line(1'b0, -1, -1);
    check("inverse_group0", 32'(grp(0)), 32'hF7);
    check("inverse_group1", 32'(grp(1)), 32'h08);
    mem[9'h040] = 8'h01;
    $display("line inverse: group0 %02h", grp(0));

    // Second line_start mid-line is ignored.
    run_line(1'b0, 100, -1);
    check("relaunch_count", cap.size(), 256);
    check("relaunch_last_active", last_act, 259);
    $display("line relaunch: %0d pixels", cap.size());

    // Reset in slot 50, then a fresh line.
    run_line(1'b0, -1, 50);
    @(negedge clk);
    check("midrst_pixel", 32'(pixel), 32'h0);
    check("midrst_active", 32'(active), 32'h0);
    check("midrst_vram_addr", 32'(vram_addr), 32'h0);
    check("midrst_font_addr", 32'(font_addr), 32'({6'd0, scan}));
    @(posedge clk); #2;
    run_line(1'b0, -1, -1);
    check("post_rst_first_active", first_act, 4);
    check("post_rst_count", cap.size(), 256);
    $display("line after reset: first active slot %0d", first_act);

    // Distinct codes per column on row 5, bit 6 set on some, inverse on odd columns.
    text_row = 4'd5;
    scan     = 4'd6;
    for (int c = 0; c < 32; c++) begin
      mem[160 + c] = 8'(8'h02 + c) | ((c % 3 == 0) ? 8'h40 : 8'h00) | ((c % 2 == 1) ? 8'h80 : 8'h00);
    end
    run_line(1'b0, -1, -1);
    check("distinct_count", cap.size(), 256);
    check("distinct_group0", 32'(grp(0)), 32'h99);
    check("distinct_group1", 32'(grp(1)), 32'h49);
    $display("line distinct: groups %02h %02h", grp(0), grp(1));

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
